muldiv_seq: RTL

//  Iterative RV32M multiply/divide unit for the execute stage. One shared XLEN-bit adder/subtractor is

---
 rtl/muldiv_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit sequenced around one shared XLEN-bit adder.
// Optional feature: define MULDIV_FAST_ZERO_EN to bypass the iteration for zero operands / zero divisor.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {IDLE, CALC, FIX_LO, FIX_HI, DONE} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] hi_reg, lo_reg, mcand_reg, result_reg;
  logic [2:0]      op_reg;
  logic [CW-1:0]   cnt_reg;
  logic            mcin_reg, neg_lo_reg, neg_hi_reg, carry_reg, busy_reg, done_reg;

  // Operand decode for the request being accepted
  logic in_div, in_s1, in_s2, in_neg1, in_neg2, div_zero;
  assign in_div   = op_i[2];
  assign in_s1    = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
  assign in_s2    = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
  assign in_neg1  = in_s1 & rs1_i[XLEN-1];
  assign in_neg2  = in_s2 & rs2_i[XLEN-1];
  assign div_zero = (rs2_i == {XLEN{1'b0}});

`ifdef MULDIV_FAST_ZERO_EN
  logic            fast_hit;
  logic [XLEN-1:0] fast_result;
  assign fast_hit    = in_div ? div_zero : ((rs1_i == {XLEN{1'b0}}) || div_zero);
  assign fast_result = !in_div ? {XLEN{1'b0}} : (op_i[1] ? rs1_i : {XLEN{1'b1}});
`endif

  // Shared adder: in IDLE/DONE it negates rs1 for the load, otherwise serves the active state.
  logic [XLEN-1:0] add_a, add_b, add_sum;
  logic            add_cin, add_cout;

  always_comb begin
    add_a   = {XLEN{1'b0}};
    add_b   = ~rs1_i;
    add_cin = 1'b1;
    case (state_reg)
      CALC: begin
        add_a   = op_reg[2] ? {hi_reg[XLEN-2:0], lo_reg[XLEN-1]} : hi_reg;
        add_b   = mcand_reg;
        add_cin = mcin_reg;
      end
      FIX_LO: begin
        add_a   = {XLEN{1'b0}};
        add_b   = ~lo_reg;
        add_cin = 1'b1;
      end
      FIX_HI: begin
        add_a   = ~hi_reg;
        add_b   = {XLEN{1'b0}};
        add_cin = op_reg[2] | carry_reg;
      end
      default: ;
    endcase
  end

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{XLEN{1'b0}}, add_cin};

  // Shifted remainder can be XLEN+1 bits wide; its lost top bit guarantees the subtraction fits.
  logic quo_bit;
  assign quo_bit = hi_reg[XLEN-1] | add_cout;

  logic [XLEN-1:0] hi_fix, res_sel;
  assign hi_fix  = neg_hi_reg ? add_sum : hi_reg;
  assign res_sel = ((op_reg == 3'd0) || (op_reg[2] && !op_reg[1])) ? lo_reg : hi_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      hi_reg     <= {XLEN{1'b0}};
      lo_reg     <= {XLEN{1'b0}};
      mcand_reg  <= {XLEN{1'b0}};
      result_reg <= {XLEN{1'b0}};
      op_reg     <= 3'd0;
      cnt_reg    <= {CW{1'b0}};
      mcin_reg   <= 1'b0;
      neg_lo_reg <= 1'b0;
      neg_hi_reg <= 1'b0;
      carry_reg  <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else if (flush_i) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          state_reg <= IDLE;
          done_reg  <= 1'b0;
          if (start_i) begin
            op_reg     <= op_i;
            hi_reg     <= {XLEN{1'b0}};
            lo_reg     <= in_neg1 ? add_sum : rs1_i;
            // A negative multiplicand adds ~b+1; a negative divisor adds b instead of subtracting |b|.
            mcand_reg  <= (in_neg2 ^ in_div) ? ~rs2_i : rs2_i;
            mcin_reg   <= in_neg2 ^ in_div;
            neg_lo_reg <= in_div ? ((in_neg1 ^ in_neg2) & ~div_zero) : (in_neg1 ^ in_neg2);
            neg_hi_reg <= in_div ? in_neg1 : (in_neg1 ^ in_neg2);
            cnt_reg    <= {CW{1'b1}};
            carry_reg  <= 1'b0;
`ifdef MULDIV_FAST_ZERO_EN
            if (fast_hit) begin
              state_reg  <= DONE;
              busy_reg   <= 1'b0;
              done_reg   <= 1'b1;
              result_reg <= fast_result;
            end else
`endif
            begin
              state_reg <= CALC;
              busy_reg  <= 1'b1;
            end
          end
        end
        CALC: begin
          if (op_reg[2]) begin
            hi_reg <= quo_bit ? add_sum : {hi_reg[XLEN-2:0], lo_reg[XLEN-1]};
            lo_reg <= {lo_reg[XLEN-2:0], quo_bit};
          end else if (lo_reg[0]) begin
            {hi_reg, lo_reg} <= {add_cout, add_sum, lo_reg[XLEN-1:1]};
          end else begin
            {hi_reg, lo_reg} <= {1'b0, hi_reg, lo_reg[XLEN-1:1]};
          end
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == {CW{1'b0}}) state_reg <= FIX_LO;
        end
        FIX_LO: begin
          if (neg_lo_reg) lo_reg <= add_sum;
          carry_reg <= add_cout;
          state_reg <= FIX_HI;
        end
        FIX_HI: begin
          hi_reg     <= hi_fix;
          result_reg <= res_sel;
          busy_reg   <= 1'b0;
          done_reg   <= 1'b1;
          state_reg  <= DONE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o   = busy_reg;
  assign done_o   = done_reg;
  assign result_o = result_reg;

endmodule
